// File: rtl/stream_comp_pkg.sv
// Shared encodings for the stream_comp actor: the mode driven to the actor
// and the scheduler state encoding, plus the mode-rotation helper.
package stream_comp_pkg;

    typedef enum logic [1:0] {
        MODE_ONE   = 2'b00,
        MODE_TWO   = 2'b01,
        MODE_THREE = 2'b10
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET_MODE,
        S_CHECK,
        S_INVOKE,
        S_WAIT_FC,
        S_DONE,
        S_ERROR
    } state_t;

    function automatic mode_t mode_after(input mode_t m);
        case (m)
            MODE_ONE: return MODE_TWO;
            MODE_TWO: return MODE_THREE;
            default:  return MODE_ONE;
        endcase
    endfunction

endpackage

// File: rtl/sched_wait_counter.sv
// Saturating wait counter shared by the stall and FC-timeout checks;
// clears whenever the scheduler is not actively waiting.
module sched_wait_counter #(
    parameter int unsigned cw = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [cw-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!inc) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stream_comp_scheduler.sv
// Drives the actor through MODE_ONE->TWO->THREE for num_iter rounds, issuing
// one invoke per mode and waiting for FC, with stall and FC-timeout guards.
module stream_comp_scheduler
    import stream_comp_pkg::*;
#(
    parameter int unsigned width       = 20,
    parameter int unsigned stall_limit = 16,
    parameter int unsigned fc_limit    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       num_iter,
    input  logic             enable,
    input  logic             FC,
    output logic [1:0]       next_mode,
    output logic             invoke,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             timeout,
    output logic [width-1:0] fire_count
);

    localparam int unsigned max_limit = (stall_limit > fc_limit) ? stall_limit : fc_limit;
    localparam int unsigned cw        = $clog2(max_limit + 1);

    state_t        state, next_state;
    mode_t         mode_q;
    logic [7:0]    iter_cnt, num_iter_q;
    logic [cw-1:0] wait_cnt, cnt_limit;
    logic          cnt_inc, cnt_last, last_round;

    // The single counter runs only while waiting in CHECK or WAIT_FC, so every
    // other state clears it for the next wait.
    assign cnt_inc    = ((state == S_CHECK) && !enable) || ((state == S_WAIT_FC) && !FC);
    assign cnt_limit  = (state == S_CHECK) ? cw'(stall_limit) : cw'(fc_limit);
    assign cnt_last   = cnt_inc && (wait_cnt == cnt_limit - 1'b1);
    assign last_round = (iter_cnt + 8'd1) == num_iter_q;
    assign next_mode  = mode_q;

    sched_wait_counter #(.cw(cw)) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .count (wait_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start) next_state = (num_iter == 8'd0) ? S_DONE : S_SET_MODE;
            S_SET_MODE: next_state = S_CHECK;
            S_CHECK: begin
                if (enable)        next_state = S_INVOKE;
                else if (cnt_last) next_state = S_ERROR;
            end
            S_INVOKE:   next_state = S_WAIT_FC;
            S_WAIT_FC: begin
                if (FC)            next_state = ((mode_q == MODE_THREE) && last_round) ? S_DONE : S_SET_MODE;
                else if (cnt_last) next_state = S_ERROR;
            end
            S_DONE:     next_state = S_IDLE;
            S_ERROR:    if (start) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they describe instead of trailing it by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_ONE;
            invoke     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stall      <= 1'b0;
            timeout    <= 1'b0;
            fire_count <= '0;
            iter_cnt   <= '0;
            num_iter_q <= '0;
        end else begin
            invoke <= (next_state == S_INVOKE);
            busy   <= (next_state != S_IDLE);
            done   <= (next_state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fire_count <= '0;
                        stall      <= 1'b0;
                        timeout    <= 1'b0;
                        iter_cnt   <= '0;
                        num_iter_q <= num_iter;
                        if (num_iter != 8'd0) mode_q <= MODE_ONE;
                    end
                end
                S_CHECK: begin
                    if (enable)        fire_count <= fire_count + 1'b1;
                    else if (cnt_last) stall <= 1'b1;
                end
                S_WAIT_FC: begin
                    if (FC) begin
                        if (mode_q == MODE_THREE) begin
                            iter_cnt <= iter_cnt + 8'd1;
                            if (!last_round) mode_q <= MODE_ONE;
                        end else begin
                            mode_q <= mode_after(mode_q);
                        end
                    end else if (cnt_last) begin
                        timeout <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (start) begin
                        stall   <= 1'b0;
                        timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
